// File: rtl/byte_data_memory.sv
//------------------------------------------------------------------------------
// byte_data_memory: byte-addressed 32-bit data memory with lb/lbu/lh/lhu/lw/sb/sh/sw,
// valid/ready request, programmable wait states and a one-cycle response pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_data_memory #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int ZERO_INIT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH     = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rsp_rdata_q;
    logic                    rsp_err_q;

    logic [ADDR_WIDTH-3:0]   w_idx;
    logic [31:0]             w_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load;
    logic [3:0]              w_be;
    logic [31:0]             w_wlanes;
    logic                    w_err;
    logic                    w_access;
    logic                    w_wr;

    assign w_idx    = addr_q[ADDR_WIDTH-1:2];
    assign w_access = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // Gating with rst_n drops a store whose access edge coincides with reset.
    assign w_wr     = w_access && rst_n && we_q && !w_err;

    assign w_err = ((addr_q >> ADDR_WIDTH) != 32'd0)
                || (size_q == 2'b11)
                || ((size_q == 2'b01) && addr_q[0])
                || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = wdata_q;
        case (size_q)
            2'b00: begin
                w_be     = 4'b0001 << addr_q[1:0];
                w_wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_be     = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata_q[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_byte = w_word[{addr_q[1:0], 3'b000} +: 8];
        w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];
        case (size_q)
            2'b00:   w_load = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    generate
        if (ZERO_INIT != 0) begin : g_zero_init
            logic [31:0] mem_q [DEPTH] = '{default: '0};
            always_ff @(posedge clk) begin
                if (w_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                    end
                end
            end
            assign w_word = mem_q[w_idx];
        end else begin : g_no_init
            logic [31:0] mem_q [DEPTH];
            always_ff @(posedge clk) begin
                if (w_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                    end
                end
            end
            assign w_word = mem_q[w_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= WAIT_INIT;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_rdata_q <= (w_err || we_q) ? 32'd0 : w_load;
                        rsp_err_q   <= w_err;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire
